// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS sequence per AHB single transfer,
// with wait-state insertion and a two-cycle ERROR on PSLVERR, unmapped slot or PREADY timeout.
module ahb_apb_bridge #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_PSLV = 4,
  parameter int unsigned PSEL_LSB = 12,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic                         hsel,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [1:0]                   htrans,
  input  logic                         hwrite,
  input  logic [2:0]                   hsize,
  input  logic [DATA_W-1:0]            hwdata,
  input  logic                         hready,
  output logic                         hreadyout,
  output logic                         hresp,
  output logic [DATA_W-1:0]            hrdata,
  output logic [ADDR_W-1:0]            paddr,
  output logic [NUM_PSLV-1:0]          psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [DATA_W-1:0]            pwdata,
  output logic [3:0]                   pstrb,
  input  logic [NUM_PSLV*DATA_W-1:0]   prdata,
  input  logic [NUM_PSLV-1:0]          pready,
  input  logic [NUM_PSLV-1:0]          pslverr
);

  // Slot field is decoded 4 bits wide so addresses past the last peripheral slot are rejected.
  localparam int unsigned SLOT_W = 4;
  localparam int unsigned IDX_W  = (NUM_PSLV > 1) ? $clog2(NUM_PSLV) : 1;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                hreadyout_d;
  logic                hresp_d;
  logic [DATA_W-1:0]   hrdata_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [NUM_PSLV-1:0] psel_d;
  logic                penable_d;
  logic                pwrite_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic [3:0]          pstrb_d;

  logic [SLOT_W-1:0]   slot;
  logic                slot_bad;
  logic                start;

  assign slot     = haddr[PSEL_LSB +: SLOT_W];
  assign slot_bad = (32'(slot) >= NUM_PSLV);
  assign start    = hsel & hready & htrans[1];

  function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    strb_of = 4'b0001 << a;
      3'd1:    strb_of = a[1] ? 4'b1100 : 4'b0011;
      default: strb_of = 4'b1111;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    hreadyout_d = hreadyout;
    hresp_d     = hresp;
    hrdata_d    = hrdata;
    paddr_d     = paddr;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    pwdata_d    = pwdata;
    pstrb_d     = pstrb;

    unique case (state_q)
      IDLE: begin
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        if (start) begin
          paddr_d     = haddr;
          pwrite_d    = hwrite;
          pstrb_d     = hwrite ? strb_of(hsize, haddr[1:0]) : 4'b0000;
          idx_d       = slot[IDX_W-1:0];
          hreadyout_d = 1'b0;
          if (slot_bad) begin
            hresp_d = 1'b1;
            state_d = ERR1;
          end else if (hwrite) begin
            state_d = WDATA;
          end else begin
            psel_d  = NUM_PSLV'(1) << slot[IDX_W-1:0];
            state_d = SETUP;
          end
        end
      end
      WDATA: begin
        pwdata_d = hwdata;
        psel_d   = NUM_PSLV'(1) << idx_q;
        state_d  = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready[idx_q]) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (pslverr[idx_q]) begin
            hresp_d = 1'b1;
            state_d = ERR1;
          end else begin
            hreadyout_d = 1'b1;
            if (!pwrite) hrdata_d = prdata[idx_q*DATA_W +: DATA_W];
            state_d = IDLE;
          end
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          hresp_d   = 1'b1;
          state_d   = ERR1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR1: begin
        hreadyout_d = 1'b1;
        state_d     = ERR2;
      end
      ERR2: begin
        hresp_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        psel_d      = '0;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Reset drops APB handshakes immediately, even mid-transfer.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      paddr     <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      hreadyout <= hreadyout_d;
      hresp     <= hresp_d;
      hrdata    <= hrdata_d;
      paddr     <= paddr_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      pwdata    <= pwdata_d;
      pstrb     <= pstrb_d;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: reads, writes, APB wait states, PSLVERR, timeout,
// unmapped slot and asynchronous reset mid-transfer, each against hand-computed values.
module tb_ahb_apb_bridge;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_PSLV = 4;

  logic                       hclk;
  logic                       hreset;
  logic                       hsel;
  logic [ADDR_W-1:0]          haddr;
  logic [1:0]                 htrans;
  logic                       hwrite;
  logic [2:0]                 hsize;
  logic [DATA_W-1:0]          hwdata;
  logic                       hready;
  logic                       hreadyout;
  logic                       hresp;
  logic [DATA_W-1:0]          hrdata;
  logic [ADDR_W-1:0]          paddr;
  logic [NUM_PSLV-1:0]        psel;
  logic                       penable;
  logic                       pwrite;
  logic [DATA_W-1:0]          pwdata;
  logic [3:0]                 pstrb;
  logic [NUM_PSLV*DATA_W-1:0] prdata;
  logic [NUM_PSLV-1:0]        pready;
  logic [NUM_PSLV-1:0]        pslverr;

  int checks = 0;
  int errors = 0;

  ahb_apb_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PSLV(NUM_PSLV), .PSEL_LSB(12), .TIMEOUT(4)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Single-slave bus: the bus-level HREADY is the bridge's own.
  assign hready = hreadyout;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  initial begin
    hreset  = 1'b1;
    hsel    = 1'b0;
    haddr   = '0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'd2;
    hwdata  = '0;
    prdata  = '0;
    pready  = 4'b1111;
    pslverr = 4'b0000;
    prdata[0*32 +: 32] = 32'h1234_5678;
    prdata[1*32 +: 32] = 32'hDEAD_BEEF;
    prdata[3*32 +: 32] = 32'hCAFE_F00D;

    #7;
    check("rst_hreadyout", 32'(hreadyout), 32'h1);
    check("rst_hresp",     32'(hresp),     32'h0);
    check("rst_hrdata",    hrdata,         32'h0);
    check("rst_psel",      32'(psel),      32'h0);
    check("rst_penable",   32'(penable),   32'h0);
    check("rst_paddr",     paddr,          32'h0);
    check("rst_pstrb",     32'(pstrb),     32'h0);
    #5 hreset = 1'b0;

    // BUSY and deselected NONSEQ must not start a transfer
    step(); hsel = 1'b1; htrans = 2'b01; haddr = 32'h1004;
    step(); check("busy_rdy", 32'(hreadyout), 32'h1); check("busy_psel", 32'(psel), 32'h0);
    hsel = 1'b0; htrans = 2'b10;
    step(); check("nosel_rdy", 32'(hreadyout), 32'h1); check("nosel_psel", 32'(psel), 32'h0);

    // Read slot 1, zero-wait APB
    addr_phase(32'h1004, 1'b0, 3'd2);
    step(); bus_idle();
    check("rd1_setup_rdy",  32'(hreadyout), 32'h0);
    check("rd1_setup_psel", 32'(psel),      32'h2);
    check("rd1_setup_pen",  32'(penable),   32'h0);
    check("rd1_paddr",      paddr,          32'h1004);
    check("rd1_pstrb",      32'(pstrb),     32'h0);
    step();
    check("rd1_acc_pen",  32'(penable),   32'h1);
    check("rd1_acc_psel", 32'(psel),      32'h2);
    check("rd1_acc_rdy",  32'(hreadyout), 32'h0);
    step();
    check("rd1_done_rdy",  32'(hreadyout), 32'h1);
    check("rd1_done_resp", 32'(hresp),     32'h0);
    check("rd1_hrdata",    hrdata,         32'hDEAD_BEEF);
    check("rd1_done_psel", 32'(psel),      32'h0);

    // Back-to-back byte write to 0x2003
    addr_phase(32'h2003, 1'b1, 3'd0);
    step(); bus_idle(); hwdata = 32'hAB00_0000;
    check("wr_wdata_rdy",  32'(hreadyout), 32'h0);
    check("wr_wdata_psel", 32'(psel),      32'h0);
    step(); hwdata = 32'h0;
    check("wr_setup_psel", 32'(psel),    32'h4);
    check("wr_pwdata",     pwdata,       32'hAB00_0000);
    check("wr_pstrb",      32'(pstrb),   32'h8);
    check("wr_pwrite",     32'(pwrite),  32'h1);
    check("wr_setup_pen",  32'(penable), 32'h0);
    step();
    check("wr_acc_pen",    32'(penable),   32'h1);
    check("wr_acc_pwdata", pwdata,         32'hAB00_0000);
    check("wr_acc_rdy",    32'(hreadyout), 32'h0);
    step();
    check("wr_done_rdy", 32'(hreadyout), 32'h1);
    check("wr_hrdata",   hrdata,         32'hDEAD_BEEF);

    // Halfword write to upper half of slot 0
    addr_phase(32'h0002, 1'b1, 3'd1);
    step(); bus_idle(); hwdata = 32'hBEEF_0000;
    step();
    check("hw_pstrb",  32'(pstrb), 32'hC);
    check("hw_pwdata", pwdata,     32'hBEEF_0000);
    check("hw_psel",   32'(psel),  32'h1);
    step(); step();
    check("hw_done_rdy", 32'(hreadyout), 32'h1);

    // Read slot 0 with three not-ready ACCESS cycles; other slaves' signals ignored
    pready = 4'b1110; pslverr = 4'b1110;
    addr_phase(32'h0010, 1'b0, 3'd2);
    step(); bus_idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("ws_rdy",   32'(hreadyout), 32'h0);
      check("ws_psel",  32'(psel),      32'h1);
      check("ws_paddr", paddr,          32'h0010);
    end
    step(); pready = 4'b1111;
    check("ws_last_pen", 32'(penable),   32'h1);
    check("ws_last_rdy", 32'(hreadyout), 32'h0);
    step(); pslverr = 4'b0000;
    check("ws_done_rdy",  32'(hreadyout), 32'h1);
    check("ws_done_resp", 32'(hresp),     32'h0);
    check("ws_hrdata",    hrdata,         32'h1234_5678);

    // PSLVERR from slot 3
    pslverr = 4'b1000;
    addr_phase(32'h3000, 1'b0, 3'd2);
    step(); bus_idle();
    check("se_setup_psel", 32'(psel), 32'h8);
    step();
    step(); pslverr = 4'b0000;
    check("se_err1_rdy",  32'(hreadyout), 32'h0);
    check("se_err1_resp", 32'(hresp),     32'h1);
    check("se_err1_psel", 32'(psel),      32'h0);
    step();
    check("se_err2_rdy",  32'(hreadyout), 32'h1);
    check("se_err2_resp", 32'(hresp),     32'h1);
    step();
    check("se_idle_resp", 32'(hresp), 32'h0);
    check("se_hrdata",    hrdata,     32'h1234_5678);

    // PREADY timeout on slot 2 (TIMEOUT=4)
    pready = 4'b1011;
    addr_phase(32'h2000, 1'b0, 3'd2);
    step(); bus_idle();
    step(); step(); step(); step();
    check("to_last_psel", 32'(psel),    32'h4);
    check("to_last_pen",  32'(penable), 32'h1);
    step(); pready = 4'b1111;
    check("to_err1_psel", 32'(psel),      32'h0);
    check("to_err1_pen",  32'(penable),   32'h0);
    check("to_err1_rdy",  32'(hreadyout), 32'h0);
    check("to_err1_resp", 32'(hresp),     32'h1);
    step();
    check("to_err2_rdy",  32'(hreadyout), 32'h1);
    check("to_err2_resp", 32'(hresp),     32'h1);
    step();
    check("to_idle_resp", 32'(hresp), 32'h0);

    // Unmapped slot 5: ERROR without any psel
    addr_phase(32'h5000, 1'b0, 3'd2);
    step(); bus_idle();
    check("bad_err1_rdy",  32'(hreadyout), 32'h0);
    check("bad_err1_resp", 32'(hresp),     32'h1);
    check("bad_err1_psel", 32'(psel),      32'h0);
    step();
    check("bad_err2_rdy",  32'(hreadyout), 32'h1);
    check("bad_err2_resp", 32'(hresp),     32'h1);
    check("bad_err2_psel", 32'(psel),      32'h0);
    step();
    check("bad_idle_resp", 32'(hresp), 32'h0);
    check("bad_idle_psel", 32'(psel),  32'h0);

    // Asynchronous reset during ACCESS, then a normal read
    pready = 4'b1101;
    addr_phase(32'h1000, 1'b0, 3'd2);
    step(); bus_idle();
    step();
    check("ar_acc_pen", 32'(penable), 32'h1);
    #2 hreset = 1'b1;
    #1;
    check("ar_psel",   32'(psel),      32'h0);
    check("ar_pen",    32'(penable),   32'h0);
    check("ar_rdy",    32'(hreadyout), 32'h1);
    check("ar_hrdata", hrdata,         32'h0);
    #3 hreset = 1'b0;
    pready = 4'b1111;
    prdata[1*32 +: 32] = 32'h0BAD_C0DE;
    step();
    addr_phase(32'h1000, 1'b0, 3'd2);
    step(); bus_idle();
    check("ar2_psel", 32'(psel), 32'h2);
    step();
    step();
    check("ar2_rdy",    32'(hreadyout), 32'h1);
    check("ar2_resp",   32'(hresp),     32'h0);
    check("ar2_hrdata", hrdata,         32'h0BAD_C0DE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
